// File: rtl/riscv_defs.sv
// riscv_defs: definitions shared by the load/store unit and the control logic.
//   - funct3 access-width constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - LOAD / STORE major opcodes
//   - load/store FSM state encodings
//   - helpers for funct3 legality and alignment checks
// No ports (package).
package riscv_defs;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_REQ    = 2'd1;
   localparam logic [1:0] S_WAIT_R = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   // Stores only have signed-width encodings; loads also allow BU/HU.
   function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
      logic ok;
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      if (!is_store)
         ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
      return ok;
   endfunction

   // funct3[1:0] carries the access size for every legal encoding.
   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
      logic mis;
      case (f3[1:0])
         2'b01:   mis = addr_lo[0];
         2'b10:   mis = (addr_lo != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane handling for the load/store unit.
// Ports:
//   funct3     in   access width/sign
//   addr_lo    in   low two address bits
//   store_data in   raw rs2 value
//   rdata      in   raw bus read word
//   be         out  byte enables for the store/load lane
//   wdata      out  lane-replicated store data
//   load_data  out  selected lane, sign- or zero-extended
// Half accesses look only at addr_lo[1] and word accesses use lane 0, so
// misaligned low bits are silently ignored when no trap is configured.
module lsu_align
   import riscv_defs::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [1:0]      addr_lo,
   input  logic [XLEN-1:0] store_data,
   input  logic [XLEN-1:0] rdata,
   output logic [3:0]      be,
   output logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] load_data
);

   logic signed [7:0]      byte_sel;
   logic signed [15:0]     half_sel;
   logic signed [XLEN-1:0] byte_ext;
   logic signed [XLEN-1:0] half_ext;

   always_comb begin
      case (addr_lo)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      // Signed-to-signed assignment sign-extends.
      byte_ext = byte_sel;
      half_ext = half_sel;
   end

   always_comb begin
      be    = 4'b1111;
      wdata = store_data;
      case (funct3[1:0])
         2'b00: begin
            be    = 4'b0001 << addr_lo;
            wdata = {4{store_data[7:0]}};
         end
         2'b01: begin
            be    = 4'b0011 << {addr_lo[1], 1'b0};
            wdata = {2{store_data[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      load_data = '0;
      case (funct3)
         F3_B:    load_data = byte_ext;
         F3_H:    load_data = half_ext;
         F3_W:    load_data = rdata;
         F3_BU:   load_data = {{(XLEN-8){1'b0}}, byte_sel};
         F3_HU:   load_data = {{(XLEN-16){1'b0}}, half_sel};
         default: load_data = '0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage unit turning one load or store into a single
// request/grant/response bus transaction, stalling upstream until done.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned half/word accesses
// skip the bus and pulse misaligned_o instead of being silently aligned).
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   valid_i, mem_to_reg_i,
//   mem_write_i, funct3_i,
//   addr_i, store_data_i          instruction controls and operands
//   stall_o                       hold upstream stages
//   load_data_o, load_valid_o     extended load result and its pulse
//   misaligned_o                  rejected-as-misaligned pulse
//   bus_req_o, bus_we_o,
//   bus_addr_o, bus_be_o,
//   bus_wdata_o                   request side of the data bus
//   bus_gnt_i, bus_rvalid_i,
//   bus_rdata_i                   grant and read response
module load_store_unit
   import riscv_defs::*;
#(
   parameter int ADDR_W = 32,
   parameter int XLEN   = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              valid_i,
   input  logic              mem_to_reg_i,
   input  logic              mem_write_i,
   input  logic [2:0]        funct3_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [XLEN-1:0]   store_data_i,
   output logic              stall_o,
   output logic [XLEN-1:0]   load_data_o,
   output logic              load_valid_o,
   output logic              misaligned_o,
   output logic              bus_req_o,
   output logic              bus_we_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [3:0]        bus_be_o,
   output logic [XLEN-1:0]   bus_wdata_o,
   input  logic              bus_gnt_i,
   input  logic              bus_rvalid_i,
   input  logic [XLEN-1:0]   bus_rdata_i
);

   logic [1:0]        state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        funct3_q;
   logic [XLEN-1:0]   sdata_q;
   logic              we_q;
   logic              mis_q;
   logic [XLEN-1:0]   load_data_q;

   logic              start;
   logic              legal;
   logic              mis_in;
   logic [3:0]        be;
   logic [XLEN-1:0]   wdata;
   logic [XLEN-1:0]   aligned;

   assign start = valid_i & (mem_to_reg_i | mem_write_i);
   // A simultaneous load+store request is treated as a store.
   assign legal = f3_legal(mem_write_i, funct3_i);

`ifdef LSU_MISALIGN_TRAP_EN
   assign mis_in = legal & f3_misaligned(funct3_i, addr_i[1:0]);
`else
   assign mis_in = 1'b0;
`endif

   lsu_align #(.XLEN(XLEN)) u_align (
      .funct3     (funct3_q),
      .addr_lo    (addr_q[1:0]),
      .store_data (sdata_q),
      .rdata      (bus_rdata_i),
      .be         (be),
      .wdata      (wdata),
      .load_data  (aligned)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         funct3_q    <= '0;
         sdata_q     <= '0;
         we_q        <= 1'b0;
         mis_q       <= 1'b0;
         load_data_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  addr_q   <= addr_i;
                  funct3_q <= funct3_i;
                  sdata_q  <= store_data_i;
                  we_q     <= mem_write_i;
                  mis_q    <= mis_in;
                  if (!legal || mis_in) begin
                     // Rejected access: no bus traffic, an illegal load returns 0.
                     if (!mem_write_i && !legal)
                        load_data_q <= '0;
                     state_q <= S_DONE;
                  end else begin
                     state_q <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (bus_gnt_i) begin
                  if (we_q) begin
                     state_q <= S_DONE;
                  end else if (bus_rvalid_i) begin
                     load_data_q <= aligned;
                     state_q     <= S_DONE;
                  end else begin
                     state_q <= S_WAIT_R;
                  end
               end
            end
            S_WAIT_R: begin
               if (bus_rvalid_i) begin
                  load_data_q <= aligned;
                  state_q     <= S_DONE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Bus fields are driven only while requesting so idle outputs stay at 0.
   assign bus_req_o    = (state_q == S_REQ);
   assign bus_we_o     = bus_req_o & we_q;
   assign bus_addr_o   = bus_req_o ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign bus_be_o     = bus_req_o ? be : 4'b0000;
   assign bus_wdata_o  = bus_req_o ? wdata : '0;

   assign stall_o      = ((state_q == S_IDLE) & start) | (state_q == S_REQ) |
                         (state_q == S_WAIT_R);
   assign load_valid_o = (state_q == S_DONE) & ~we_q & ~mis_q;
   assign misaligned_o = (state_q == S_DONE) & mis_q;
   assign load_data_o  = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit.
// Covers the LSU_MISALIGN_TRAP_EN build when that macro is defined.
module tb_load_store_unit;

   logic        clk;
   logic        rst_n;
   logic        valid;
   logic        mem_to_reg;
   logic        mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic        stall;
   logic [31:0] load_data;
   logic        load_valid;
   logic        misaligned;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_gnt;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;

   int errors = 0;
   int checks = 0;

   load_store_unit #(.ADDR_W(32), .XLEN(32)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .valid_i      (valid),
      .mem_to_reg_i (mem_to_reg),
      .mem_write_i  (mem_write),
      .funct3_i     (funct3),
      .addr_i       (addr),
      .store_data_i (store_data),
      .stall_o      (stall),
      .load_data_o  (load_data),
      .load_valid_o (load_valid),
      .misaligned_o (misaligned),
      .bus_req_o    (bus_req),
      .bus_we_o     (bus_we),
      .bus_addr_o   (bus_addr),
      .bus_be_o     (bus_be),
      .bus_wdata_o  (bus_wdata),
      .bus_gnt_i    (bus_gnt),
      .bus_rvalid_i (bus_rvalid),
      .bus_rdata_i  (bus_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; drive and sample 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Load with grant at T+1 and read data at T+2.
   task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] rd, input logic [3:0] ebe,
                          input logic [31:0] exp);
      valid = 1'b1; mem_to_reg = 1'b1; mem_write = 1'b0; funct3 = f3; addr = a;
      #1;
      chk({tag, "_stall_T"}, {31'b0, stall}, 32'd1);
      step();
      valid = 1'b0; mem_to_reg = 1'b0;
      chk({tag, "_req"}, {31'b0, bus_req}, 32'd1);
      chk({tag, "_addr"}, bus_addr, a & 32'hFFFF_FFFC);
      chk({tag, "_be"}, {28'b0, bus_be}, {28'b0, ebe});
      chk({tag, "_we"}, {31'b0, bus_we}, 32'd0);
      bus_gnt = 1'b1;
      step();
      bus_gnt = 1'b0;
      chk({tag, "_stall_wait"}, {31'b0, stall}, 32'd1);
      chk({tag, "_req_wait"}, {31'b0, bus_req}, 32'd0);
      bus_rvalid = 1'b1; bus_rdata = rd;
      step();
      bus_rvalid = 1'b0; bus_rdata = 32'h0;
      chk({tag, "_lvalid"}, {31'b0, load_valid}, 32'd1);
      chk({tag, "_data"}, load_data, exp);
      chk({tag, "_stall_done"}, {31'b0, stall}, 32'd0);
      step();
      chk({tag, "_lvalid_off"}, {31'b0, load_valid}, 32'd0);
      chk({tag, "_data_hold"}, load_data, exp);
   endtask

   // Store whose grant arrives after 'delay' extra request cycles.
   task automatic do_store(input string tag, input logic [31:0] a, input logic [2:0] f3,
                           input logic [31:0] d, input logic [3:0] ebe,
                           input logic [31:0] ewd, input int delay, input logic also_load);
      valid = 1'b1; mem_to_reg = also_load; mem_write = 1'b1; funct3 = f3; addr = a;
      store_data = d;
      #1;
      chk({tag, "_stall_T"}, {31'b0, stall}, 32'd1);
      step();
      valid = 1'b0; mem_to_reg = 1'b0; mem_write = 1'b0; store_data = 32'h0;
      for (int i = 0; i < delay; i++) begin
         chk({tag, "_req_hold"}, {31'b0, bus_req}, 32'd1);
         chk({tag, "_addr_hold"}, bus_addr, a & 32'hFFFF_FFFC);
         chk({tag, "_stall_hold"}, {31'b0, stall}, 32'd1);
         step();
      end
      chk({tag, "_req"}, {31'b0, bus_req}, 32'd1);
      chk({tag, "_we"}, {31'b0, bus_we}, 32'd1);
      chk({tag, "_be"}, {28'b0, bus_be}, {28'b0, ebe});
      chk({tag, "_wdata"}, bus_wdata, ewd);
      bus_gnt = 1'b1;
      step();
      bus_gnt = 1'b0;
      chk({tag, "_stall_done"}, {31'b0, stall}, 32'd0);
      chk({tag, "_req_done"}, {31'b0, bus_req}, 32'd0);
      chk({tag, "_lvalid"}, {31'b0, load_valid}, 32'd0);
      step();
   endtask

   initial begin
      rst_n = 1'b0; valid = 1'b0; mem_to_reg = 1'b0; mem_write = 1'b0;
      funct3 = 3'b000; addr = 32'h0; store_data = 32'h0;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
      #12;
      chk("rst_stall", {31'b0, stall}, 32'd0);
      chk("rst_req", {31'b0, bus_req}, 32'd0);
      chk("rst_data", load_data, 32'h0);
      chk("rst_lvalid", {31'b0, load_valid}, 32'd0);
      chk("rst_mis", {31'b0, misaligned}, 32'd0);
      chk("rst_be", {28'b0, bus_be}, 32'd0);
      step();
      rst_n = 1'b1;
      step();

      do_load("lb", 32'h0000_1003, 3'b000, 32'h80FF_FF7F, 4'b1000, 32'hFFFF_FF80);
      do_load("lhu", 32'h0000_2002, 3'b101, 32'hBEEF_1234, 4'b1100, 32'h0000_BEEF);
      do_load("lh", 32'h0000_2002, 3'b001, 32'hBEEF_1234, 4'b1100, 32'hFFFF_BEEF);
      do_load("lbu", 32'h0000_2001, 3'b100, 32'hBEEF_9234, 4'b0010, 32'h0000_0092);

      do_store("sb", 32'h0000_3001, 3'b000, 32'h1234_56AB, 4'b0010, 32'hABAB_ABAB, 5, 1'b0);
      do_store("sw", 32'h0000_5000, 3'b010, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 0, 1'b0);
      do_store("sh", 32'h0000_5002, 3'b001, 32'h1234_CAFE, 4'b1100, 32'hCAFE_CAFE, 1, 1'b0);
      // Load and store both requested: must behave as a store.
      do_store("both", 32'h0000_5003, 3'b000, 32'h0000_0055, 4'b1000, 32'h5555_5555, 0, 1'b1);

      // Grant and rvalid in the same cycle skip WAIT_R.
      valid = 1'b1; mem_to_reg = 1'b1; funct3 = 3'b010; addr = 32'h0000_6000;
      step();
      valid = 1'b0; mem_to_reg = 1'b0;
      bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
      step();
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
      chk("fast_lvalid", {31'b0, load_valid}, 32'd1);
      chk("fast_data", load_data, 32'h1234_5678);
      step();

      // Reset in WAIT_R abandons the load; a late rvalid is ignored.
      valid = 1'b1; mem_to_reg = 1'b1; funct3 = 3'b100; addr = 32'h0000_7000;
      step();
      valid = 1'b0; mem_to_reg = 1'b0; bus_gnt = 1'b1;
      step();
      bus_gnt = 1'b0;
      chk("rstw_stall_pre", {31'b0, stall}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rstw_stall", {31'b0, stall}, 32'd0);
      chk("rstw_data", load_data, 32'h0);
      step();
      rst_n = 1'b1;
      bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
      step();
      bus_rvalid = 1'b0; bus_rdata = 32'h0;
      chk("rstw_lvalid", {31'b0, load_valid}, 32'd0);
      chk("rstw_req", {31'b0, bus_req}, 32'd0);
      chk("rstw_data2", load_data, 32'h0);
      step();

      // Illegal load funct3 after a load that left nonzero data.
      do_load("lw", 32'h0000_6004, 3'b010, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
      valid = 1'b1; mem_to_reg = 1'b1; funct3 = 3'b011; addr = 32'h0000_8000;
      #1;
      chk("ill_stall_T", {31'b0, stall}, 32'd1);
      step();
      valid = 1'b0; mem_to_reg = 1'b0;
      chk("ill_req", {31'b0, bus_req}, 32'd0);
      chk("ill_stall", {31'b0, stall}, 32'd0);
      chk("ill_data", load_data, 32'h0);
      step();
      // Illegal store funct3.
      valid = 1'b1; mem_write = 1'b1; funct3 = 3'b100; addr = 32'h0000_8004;
      step();
      valid = 1'b0; mem_write = 1'b0;
      chk("ills_req", {31'b0, bus_req}, 32'd0);
      chk("ills_stall", {31'b0, stall}, 32'd0);
      step();

      // Misaligned word load.
      valid = 1'b1; mem_to_reg = 1'b1; funct3 = 3'b010; addr = 32'h0000_4002;
      step();
      valid = 1'b0; mem_to_reg = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      chk("mis_req", {31'b0, bus_req}, 32'd0);
      chk("mis_pulse", {31'b0, misaligned}, 32'd1);
      chk("mis_lvalid", {31'b0, load_valid}, 32'd0);
      step();
      chk("mis_pulse_off", {31'b0, misaligned}, 32'd0);
`else
      chk("mis_req", {31'b0, bus_req}, 32'd1);
      chk("mis_addr", bus_addr, 32'h0000_4000);
      chk("mis_be", {28'b0, bus_be}, 32'h0000_000F);
      bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hA1B2_C3D4;
      step();
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
      chk("mis_lvalid", {31'b0, load_valid}, 32'd1);
      chk("mis_data", load_data, 32'hA1B2_C3D4);
      chk("mis_pulse", {31'b0, misaligned}, 32'd0);
      step();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage consumer of the decoder's mem_to_reg / mem_write / funct3 controls.
- Turns one load or store per instruction into a single request/grant/response transaction on the data bus.
- Aligns byte lanes and sign- or zero-extends load data.
- Stalls the pipeline until the access completes.
- Sits between the decode/execute stage (address from ALU, rs2 data) and the writeback mux.

Parameters:
- ADDR_W, 32, byte-address width on address input and bus.
- XLEN, 32, data width; only 32 is supported.

Ports:
- clk_i  in  1  single clock; all state on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- valid_i  in  1  instruction in this stage is valid.
- mem_to_reg_i  in  1  load request, from control logic.
- mem_write_i  in  1  store request, from control logic.
- funct3_i  in  3  access width/sign.
- addr_i  in  ADDR_W  effective byte address.
- store_data_i  in  XLEN  rs2 value.
- stall_o  out  1  hold upstream stages.
- load_data_o  out  XLEN  extended load result.
- load_valid_o  out  1  one-cycle pulse; load_data_o is valid.
- misaligned_o  out  1  one-cycle pulse; access rejected as misaligned.
- bus_req_o  out  1  bus request.
- bus_we_o  out  1  1 = write.
- bus_addr_o  out  ADDR_W  word-aligned address, low 2 bits = 0.
- bus_be_o  out  4  byte enables.
- bus_wdata_o  out  XLEN  lane-replicated store data.
- bus_gnt_i  in  1  request accepted.
- bus_rvalid_i  in  1  read data valid.
- bus_rdata_i  in  XLEN  read data.

Behaviour:
- Reset:
  - Asynchronous on rst_ni low; state goes to IDLE.
  - All outputs and latched registers go to 0.
  - Reset mid-transaction abandons it; a later bus_rvalid_i seen in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT_R, DONE.
- IDLE:
  - start = valid_i & (mem_to_reg_i | mem_write_i).
  - stall_o = start, combinational in the same cycle.
  - On start: latch addr, funct3, store data and we = mem_write_i, then go to REQ.
  - If mem_write_i and mem_to_reg_i are both high, treat the access as a store.
- REQ:
  - bus_req_o = 1; bus_addr/we/be/wdata are held stable until bus_gnt_i.
  - On grant, a store goes to DONE.
  - On grant, a load goes to WAIT_R; if bus_rvalid_i is also high that cycle, the load captures data and goes straight to DONE.
- WAIT_R: on bus_rvalid_i, capture and extend data, then go to DONE.
- DONE:
  - stall_o = 0.
  - load_valid_o = 1 for loads only.
  - Next state is IDLE; a new start is not accepted in DONE.
- stall_o is 1 in REQ and WAIT_R.
- Upstream holds its inputs stable while stall_o is high.
- Latency:
  - Load accepted at cycle T with gnt at T+1 and rvalid at T+2 gives load_valid_o at T+3.
  - Store under the same timing releases the stall at T+2.
- Byte enables:
  - Byte: 4'b0001 << addr[1:0].
  - Half: 4'b0011 << {addr[1],1'b0}.
  - Word: 4'b1111.
- wdata: SB = {4{data[7:0]}}, SH = {2{data[15:0]}}, SW = data.
- Load funct3 decode:
  - 000 LB: sign-extend the selected byte.
  - 001 LH: sign-extend the selected half.
  - 010 LW.
  - 100 LBU and 101 LHU: zero-extend.
  - Any other funct3: illegal.
- Store funct3 decode: 000/001/010 are legal; others are illegal.
- Illegal funct3: no bus request; go to DONE with load_data_o = 0.
- load_data_o holds its value until the next load completes.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Misaligned means a half access with addr[0]=1, or a word access with addr[1:0]!=0.
- With the macro defined:
  - A misaligned access issues no bus request.
  - The FSM goes IDLE->DONE.
  - In DONE, misaligned_o = 1 and load_valid_o = 0.
- Without the macro:
  - misaligned_o is tied to 0.
  - Low address bits beyond the access size are ignored: half uses addr[1], word uses lane 0.
  - The access proceeds normally.

Decomposition:
- Shared include/package riscv_defs holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - LOAD/STORE opcode constants, also used by the control logic.
  - FSM state encodings.
- One natural sub-module, lsu_align: combinational lane select plus sign/zero extension for loads, and byte-enable/wdata generation for stores.

Test Plan:
- LB at addr 0x1003, rdata 0x80FF_FF7F, gnt at T+1, rvalid at T+2 -> load_data_o = 0xFFFF_FF80, load_valid_o at T+3, bus_addr 0x1000.
- LHU at 0x2002, rdata 0xBEEF_1234 -> load_data_o 0x0000_BEEF; LH at the same address -> 0xFFFF_BEEF.
- SB 0xAB at 0x3001 -> bus_be 4'b0010, wdata 0xABAB_ABAB, we=1; gnt delayed 5 cycles keeps req/addr stable and stall_o high until the grant.
- Load with gnt and rvalid in the same cycle -> WAIT_R skipped, load_valid_o the next cycle.
- rst_ni pulsed low in WAIT_R, then rvalid -> outputs 0 and no load_valid_o.
- With LSU_MISALIGN_TRAP_EN defined, LW at 0x4002 -> no bus_req_o and a misaligned_o pulse. Without it -> word read at 0x4000.
